// File: rtl/matrix_op_sequencer_if.sv
// Handshake and buffer bus between the main buffer/HPS side and the
// matrix operation sequencer. The master side issues start/instruction and
// returns operand data; the slave (sequencer) drives reads, writes and status.
interface matrix_op_sequencer_if #(
  parameter int EW = 8
);
  logic                 start;
  logic [5:0]           instruction;
  logic                 rd_en;
  logic [2:0]           rd_a_row;
  logic [2:0]           rd_a_col;
  logic [2:0]           rd_b_row;
  logic [2:0]           rd_b_col;
  logic signed [EW-1:0] a_elem;
  logic signed [EW-1:0] b_elem;
  logic                 wr_en;
  logic [2:0]           wr_row;
  logic [2:0]           wr_col;
  logic signed [EW-1:0] wr_data;
  logic                 busy;
  logic                 done;
  logic                 error;
  logic                 ovf;

  modport master (
    output start, instruction, a_elem, b_elem,
    input  rd_en, rd_a_row, rd_a_col, rd_b_row, rd_b_col,
    input  wr_en, wr_row, wr_col, wr_data, busy, done, error, ovf
  );

  modport slave (
    input  start, instruction, a_elem, b_elem,
    output rd_en, rd_a_row, rd_a_col, rd_b_row, rd_b_col,
    output wr_en, wr_row, wr_col, wr_data, busy, done, error, ovf
  );
endinterface

// File: rtl/matrix_op_sequencer.sv
// Sequencer for 5x5 signed matrix ADD/SUB/MUL/TRANSPOSE/NEGATE.
// Stage p0 issues element reads; stage p1 receives operand data one cycle
// later, accumulates (MUL) and writes the result element.
// Build option: define MATRIX_SEQ_SATURATE_EN to clip results to the signed
// element range and report clipping on ovf; otherwise results wrap.
module matrix_op_sequencer #(
  parameter int N  = 5,
  parameter int EW = 8
) (
  input logic                  clk,
  input logic                  rst,
  matrix_op_sequencer_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_TRN = 3'd3;
  localparam logic [2:0] OP_NEG = 3'd4;
  localparam int         ACC_W  = 2*EW + 4;
  localparam logic [2:0] LAST   = 3'(N-1);

`ifdef MATRIX_SEQ_SATURATE_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  // Clip a wide signed value to EW bits; MSB of the result flags clipping.
  function automatic logic [EW:0] sat_fn(input logic signed [ACC_W-1:0] v);
    if ((&v[ACC_W-1:EW-1]) || !(|v[ACC_W-1:EW-1]))
      sat_fn = {1'b0, v[EW-1:0]};
    else if (v[ACC_W-1])
      sat_fn = {1'b1, 1'b1, {(EW-1){1'b0}}};
    else
      sat_fn = {1'b1, 1'b0, {(EW-1){1'b1}}};
  endfunction

  state_t     r_state;
  logic [2:0] r_op;
  logic [2:0] r_row, r_col, r_k;
  logic       r_rd_en, r_busy, r_done, r_error, r_ovf;

  logic                    r_vld_p1;
  logic                    r_first_p1, r_last_p1;
  logic [2:0]              r_wr_row_p1, r_wr_col_p1;
  logic signed [ACC_W-1:0] r_acc_p1;

  logic w_is_mul, w_last_rd, w_op_valid;
  logic w_unused_instr;

  assign w_is_mul       = (r_op == OP_MUL);
  assign w_last_rd      = (r_row == LAST) && (r_col == LAST) && (!w_is_mul || (r_k == LAST));
  assign w_op_valid     = (bus.instruction[2:0] <= OP_NEG);
  assign w_unused_instr = ^bus.instruction[5:3];

  // ---- p0: read address generation (indices forced to 0 when idle)
  // Map the element counters to A/B read indices for the latched opcode.
  always_comb begin
    bus.rd_a_row = 3'd0;
    bus.rd_a_col = 3'd0;
    bus.rd_b_row = 3'd0;
    bus.rd_b_col = 3'd0;
    if (r_rd_en) begin
      case (r_op)
        OP_MUL: begin
          bus.rd_a_row = r_row; bus.rd_a_col = r_k;
          bus.rd_b_row = r_k;   bus.rd_b_col = r_col;
        end
        OP_TRN: begin
          bus.rd_a_row = r_col; bus.rd_a_col = r_row;
          bus.rd_b_row = r_row; bus.rd_b_col = r_col;
        end
        default: begin
          bus.rd_a_row = r_row; bus.rd_a_col = r_col;
          bus.rd_b_row = r_row; bus.rd_b_col = r_col;
        end
      endcase
    end
  end

  // ---- p1: operand data present, compute result element
  logic signed [EW:0]      w_a9_p1, w_b9_p1, w_add_p1, w_sub_p1, w_neg_p1;
  logic signed [2*EW-1:0]  w_prod_p1;
  logic signed [ACC_W-1:0] w_prod_ext_p1, w_sum_p1, w_res_p1;
  logic [EW:0]             w_sat_p1;
  logic signed [EW-1:0]    w_wr_data_p1;
  logic                    w_wr_en_p1, w_clip_p1;

  assign w_a9_p1       = {bus.a_elem[EW-1], bus.a_elem};
  assign w_b9_p1       = {bus.b_elem[EW-1], bus.b_elem};
  assign w_add_p1      = w_a9_p1 + w_b9_p1;
  assign w_sub_p1      = w_a9_p1 - w_b9_p1;
  assign w_neg_p1      = -w_a9_p1;
  assign w_prod_p1     = bus.a_elem * bus.b_elem;
  assign w_prod_ext_p1 = {{(ACC_W-2*EW){w_prod_p1[2*EW-1]}}, w_prod_p1};
  assign w_sum_p1      = (r_first_p1 ? {ACC_W{1'b0}} : r_acc_p1) + w_prod_ext_p1;

  // Select the wide signed result for the latched opcode.
  always_comb begin
    w_res_p1 = {{(ACC_W-EW-1){w_a9_p1[EW]}}, w_a9_p1};
    case (r_op)
      OP_ADD:  w_res_p1 = {{(ACC_W-EW-1){w_add_p1[EW]}}, w_add_p1};
      OP_SUB:  w_res_p1 = {{(ACC_W-EW-1){w_sub_p1[EW]}}, w_sub_p1};
      OP_MUL:  w_res_p1 = w_sum_p1;
      OP_NEG:  w_res_p1 = {{(ACC_W-EW-1){w_neg_p1[EW]}}, w_neg_p1};
      default: w_res_p1 = {{(ACC_W-EW-1){w_a9_p1[EW]}}, w_a9_p1};
    endcase
  end

  assign w_sat_p1     = sat_fn(w_res_p1);
  assign w_wr_data_p1 = SAT_EN ? w_sat_p1[EW-1:0] : w_res_p1[EW-1:0];
  assign w_clip_p1    = SAT_EN & w_sat_p1[EW];
  assign w_wr_en_p1   = r_vld_p1 & r_last_p1;

  assign bus.wr_en   = w_wr_en_p1;
  assign bus.wr_row  = w_wr_en_p1 ? r_wr_row_p1 : 3'd0;
  assign bus.wr_col  = w_wr_en_p1 ? r_wr_col_p1 : 3'd0;
  assign bus.wr_data = w_wr_en_p1 ? w_wr_data_p1 : {EW{1'b0}};
  assign bus.rd_en   = r_rd_en;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.error   = r_error;
  assign bus.ovf     = r_ovf;

  // Data-path stage registers: p1 tags and the MUL accumulator need no reset.
  always_ff @(posedge clk) begin
    r_wr_row_p1 <= r_row;
    r_wr_col_p1 <= r_col;
    r_first_p1  <= (r_k == 3'd0);
    r_last_p1   <= !w_is_mul || (r_k == LAST);
    if (r_vld_p1 && w_is_mul)
      r_acc_p1 <= w_sum_p1;
  end

  // Control FSM: accepts start in IDLE, walks the element counters in RUN,
  // lets the last write retire in DRAIN and pulses done in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_op     <= 3'd0;
      r_row    <= 3'd0;
      r_col    <= 3'd0;
      r_k      <= 3'd0;
      r_rd_en  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_error  <= 1'b0;
      r_ovf    <= 1'b0;
      r_vld_p1 <= 1'b0;
    end else begin
      r_vld_p1 <= r_rd_en;
      if (w_wr_en_p1 && w_clip_p1)
        r_ovf <= 1'b1;
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_op   <= bus.instruction[2:0];
            r_busy <= 1'b1;
            r_ovf  <= 1'b0;
            if (w_op_valid) begin
              r_error <= 1'b0;
              r_rd_en <= 1'b1;
              r_state <= S_RUN;
            end else begin
              r_error <= 1'b1;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end
        S_RUN: begin
          if (w_last_rd) begin
            r_rd_en <= 1'b0;
            r_row   <= 3'd0;
            r_col   <= 3'd0;
            r_k     <= 3'd0;
            r_state <= S_DRAIN;
          end else if (w_is_mul && (r_k != LAST)) begin
            r_k <= r_k + 3'd1;
          end else begin
            r_k <= 3'd0;
            if (r_col == LAST) begin
              r_col <= 3'd0;
              r_row <= r_row + 3'd1;
            end else begin
              r_col <= r_col + 3'd1;
            end
          end
        end
        S_DRAIN: begin
          r_done  <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_op_sequencer.sv
// Self-checking bench for matrix_op_sequencer: directed cases plus
// randomized matrices/opcodes against a plain-arithmetic reference model.
module tb_matrix_op_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  matrix_op_sequencer_if ifc ();

  matrix_op_sequencer u_dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  int A [5][5];
  int B [5][5];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; act as the main buffer (data one cycle after rd_en).
  task automatic step();
    bit pend;
    int ar, ac, br, bc;
    pend = ifc.rd_en;
    ar = int'(ifc.rd_a_row); ac = int'(ifc.rd_a_col);
    br = int'(ifc.rd_b_row); bc = int'(ifc.rd_b_col);
    @(posedge clk);
    #1;
    ifc.start = 1'b0;
    rst       = 1'b0;
    if (pend && ar < 5 && ac < 5 && br < 5 && bc < 5) begin
      ifc.a_elem = 8'(A[ar][ac]);
      ifc.b_elem = 8'(B[br][bc]);
    end else begin
      ifc.a_elem = 8'($urandom);
      ifc.b_elem = 8'($urandom);
    end
    #1;
  endtask

  function automatic int model_raw(input int op, input int r, input int c);
    int s;
    case (op)
      0: return A[r][c] + B[r][c];
      1: return A[r][c] - B[r][c];
      2: begin
        s = 0;
        for (int k = 0; k < 5; k++) s += A[r][k] * B[k][c];
        return s;
      end
      3: return A[c][r];
      default: return -A[r][c];
    endcase
  endfunction

  function automatic int fit(input int v, output bit clip);
`ifdef MATRIX_SEQ_SATURATE_EN
    clip = (v > 127) || (v < -128);
    return (v > 127) ? 127 : ((v < -128) ? -128 : v);
`else
    logic signed [7:0] t;
    clip = 1'b0;
    t = v[7:0];
    return int'(t);
`endif
  endfunction

  // Run one operation from start; rst_cyc >= 0 aborts with reset in that cycle.
  task automatic run_op(input string name, input logic [5:0] instr, input int pulse_cyc,
                        input logic [5:0] pulse_instr, input int rst_cyc);
    int  op, donecyc, nexp_rd, nexp_wr, wi, rd_cnt, busy_bad, idx_bad, post_bad, cyc, last_cyc;
    bit  valid, done_seen, exp_ovf, clip;
    int  exp_data [25];
    op = int'(instr[2:0]);
    valid = (op <= 4);
    exp_ovf = 1'b0;
    for (int i = 0; i < 25; i++) begin
      exp_data[i] = valid ? fit(model_raw(op, i / 5, i % 5), clip) : 0;
      if (valid && clip) exp_ovf = 1'b1;
    end
    donecyc  = !valid ? 1 : (op == 2 ? 127 : 27);
    nexp_rd  = !valid ? 0 : (op == 2 ? 125 : 25);
    nexp_wr  = valid ? 25 : 0;
    last_cyc = (rst_cyc >= 0) ? rst_cyc + 6 : donecyc + 2;
    wi = 0; rd_cnt = 0; busy_bad = 0; idx_bad = 0; post_bad = 0; done_seen = 1'b0;

    ifc.instruction = instr;
    ifc.start = 1'b1;
    step();
    cyc = 1;
    chk($sformatf("%s.error_c1", name), int'(ifc.error), valid ? 0 : 1);
    while (cyc <= last_cyc) begin
      if (ifc.rd_en) rd_cnt++;
      else if ((ifc.rd_a_row | ifc.rd_a_col | ifc.rd_b_row | ifc.rd_b_col) != 3'd0) idx_bad++;
      if (!ifc.wr_en && (ifc.wr_row != 3'd0 || ifc.wr_col != 3'd0 || ifc.wr_data != 8'sd0)) idx_bad++;
      if (rst_cyc >= 0 && cyc > rst_cyc) begin
        if (ifc.rd_en || ifc.wr_en || ifc.busy || ifc.done || ifc.error || ifc.ovf) post_bad++;
      end else begin
        if (ifc.busy !== (cyc <= donecyc)) busy_bad++;
        if (ifc.wr_en) begin
          if (wi < nexp_wr) begin
            chk($sformatf("%s.wr_cyc[%0d]", name, wi), cyc, (op == 2) ? 6 + 5 * wi : 2 + wi);
            chk($sformatf("%s.wr_row[%0d]", name, wi), int'(ifc.wr_row), wi / 5);
            chk($sformatf("%s.wr_col[%0d]", name, wi), int'(ifc.wr_col), wi % 5);
            chk($sformatf("%s.wr_data[%0d]", name, wi), int'(ifc.wr_data), exp_data[wi]);
          end else begin
            chk($sformatf("%s.extra_wr", name), wi + 1, nexp_wr);
          end
          wi++;
        end
        if (ifc.done) begin
          chk($sformatf("%s.done_cyc", name), cyc, donecyc);
          chk($sformatf("%s.error", name), int'(ifc.error), valid ? 0 : 1);
          chk($sformatf("%s.ovf", name), int'(ifc.ovf), int'(exp_ovf));
          done_seen = 1'b1;
        end
      end
      if (cyc == pulse_cyc) begin
        ifc.start = 1'b1;
        ifc.instruction = pulse_instr;
      end
      if (cyc == rst_cyc) rst = 1'b1;
      step();
      cyc++;
    end
    if (rst_cyc >= 0) begin
      chk($sformatf("%s.post_rst_activity", name), post_bad, 0);
      chk($sformatf("%s.rd_cnt", name), rd_cnt, (rst_cyc < nexp_rd) ? rst_cyc : nexp_rd);
    end else begin
      chk($sformatf("%s.done_seen", name), int'(done_seen), 1);
      chk($sformatf("%s.wr_cnt", name), wi, nexp_wr);
      chk($sformatf("%s.rd_cnt", name), rd_cnt, nexp_rd);
    end
    chk($sformatf("%s.busy_bad_cycles", name), busy_bad, 0);
    chk($sformatf("%s.idle_index_bad", name), idx_bad, 0);
  endtask

  initial begin
    ifc.start = 1'b0;
    ifc.instruction = 6'd0;
    ifc.a_elem = 8'sd0;
    ifc.b_elem = 8'sd0;
    rst = 1'b1;
    step();
    rst = 1'b1;
    step();

    chk("reset.rd_en", int'(ifc.rd_en), 0);
    chk("reset.rd_idx", int'({ifc.rd_a_row, ifc.rd_a_col, ifc.rd_b_row, ifc.rd_b_col}), 0);
    chk("reset.wr_en", int'(ifc.wr_en), 0);
    chk("reset.wr_out", int'({ifc.wr_row, ifc.wr_col, ifc.wr_data}), 0);
    chk("reset.status", int'({ifc.busy, ifc.done, ifc.error, ifc.ovf}), 0);

    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) begin A[r][c] = r * 5 + c; B[r][c] = 1; end
    run_op("add_seq", 6'b000000, -1, 6'd0, -1);

    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) begin A[r][c] = (r == c) ? 1 : 0; B[r][c] = r - c; end
    run_op("mul_ident", 6'b000010, -1, 6'd0, -1);

    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) begin A[r][c] = 100; B[r][c] = 100; end
    run_op("add_100", 6'b000000, -1, 6'd0, -1);

    run_op("invalid", 6'b000111, -1, 6'd0, -1);
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) begin A[r][c] = -128 + 10 * r + c; B[r][c] = 3 * c - r; end
    run_op("after_invalid_sub", 6'b101001, -1, 6'd0, -1);

    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) begin
        A[r][c] = int'($urandom_range(0, 255)) - 128;
        B[r][c] = int'($urandom_range(0, 255)) - 128;
      end
    run_op("mul_rst40", 6'b000010, -1, 6'd0, 40);
    run_op("add_after_rst", 6'b000000, -1, 6'd0, -1);

    run_op("add_pulse_mul", 6'b000000, 10, 6'b000010, -1);

    A[0][0] = -128;
    run_op("neg", 6'b000100, -1, 6'd0, -1);
    run_op("transpose", 6'b011011, -1, 6'd0, -1);

    for (int t = 0; t < 8; t++) begin
      for (int r = 0; r < 5; r++)
        for (int c = 0; c < 5; c++) begin
          A[r][c] = int'($urandom_range(0, 255)) - 128;
          B[r][c] = int'($urandom_range(0, 255)) - 128;
        end
      run_op($sformatf("rand%0d", t), 6'($urandom_range(0, 63)), -1, 6'd0, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
